// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NUM_MASTERS masters share one slave port.
// Ownership is held for a whole wbm_cyc_i cycle. A watchdog aborts stalled strobes with err.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbm_*_i                   packed per-master requests (master i at slice i)
//   wbm_dat_o                 read data, broadcast to all masters
//   wbm_ack_o/err_o/rty_o     per-master responses, owner only
//   wbs_*_o / wbs_*_i         shared slave port
//   grant_o                   one-hot current owner, zero when idle
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  // In BUSY, r_last is also the current owner.
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_last_nxt;
  logic [IW-1:0] w_hi;
  logic [IW-1:0] w_lo;
  logic [IW-1:0] w_pick;
  logic          w_hi_found;
  logic          w_lo_found;
  logic          w_found;
  logic          w_busy;
  logic          w_own_cyc;
  logic          w_own_stb;
  logic          r_abort;

  assign w_busy    = (r_state == S_BUSY);
  assign w_own_cyc = wbm_cyc_i[r_last];
  assign w_own_stb = wbm_stb_i[r_last];
  assign wbm_dat_o = wbs_dat_i;

  // Two-pass search: lowest requester above r_last wins;
  // otherwise wrap to the lowest one at or below it.
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (wbm_cyc_i[i]) begin
        if (IW'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi       = IW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo       = IW'(i);
        end
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_pick  = w_hi_found ? w_hi : w_lo;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
          w_last_nxt  = w_pick;
        end
      end
      S_BUSY: begin
        if (!w_own_cyc) begin
          if (w_found) begin
            w_last_nxt = w_pick;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_o   = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (w_busy) begin
      grant_o[r_last] = 1'b1;
      wbs_adr_o = wbm_adr_i[r_last*AW +: AW];
      wbs_dat_o = wbm_dat_i[r_last*DW +: DW];
      wbs_sel_o = wbm_sel_i[r_last*SW +: SW];
      wbs_we_o  = wbm_we_i[r_last];
      wbs_cyc_o = w_own_cyc & ~r_abort;
      wbs_stb_o = w_own_stb & ~r_abort;
      wbs_cti_o = wbm_cti_i[r_last*3 +: 3];
      wbs_bte_o = wbm_bte_i[r_last*2 +: 2];
    end
    // A late slave ack in the abort cycle is dropped.
    wbm_ack_o = grant_o & {NUM_MASTERS{wbs_ack_i & ~r_abort}};
    wbm_rty_o = grant_o & {NUM_MASTERS{wbs_rty_i & ~r_abort}};
    wbm_err_o = grant_o & {NUM_MASTERS{wbs_err_i | r_abort}};
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_stall;

    assign w_stall = w_busy & w_own_cyc & w_own_stb & ~r_abort &
                     ~(wbs_ack_i | wbs_err_i | wbs_rty_i);

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if (!w_stall) begin
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if (r_cnt == TMAX) begin
        r_cnt   <= '0;
        r_abort <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_abort <= 1'b0;
      end
    end
  end else begin : g_nowd
    assign r_abort = 1'b0;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (2 masters, TIMEOUT=8).
// Expected acks are queued per master at stimulus time and popped by a monitor.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m_adr [N];
  logic [31:0] m_dat [N];
  logic [2:0]  m_cti [N];
  logic        m_cyc [N];
  logic        m_stb [N];
  logic        m_we  [N];

  logic [N*32-1:0] wbm_adr_i;
  logic [N*32-1:0] wbm_dat_i;
  logic [N*4-1:0]  wbm_sel_i;
  logic [N-1:0]    wbm_we_i;
  logic [N-1:0]    wbm_cyc_i;
  logic [N-1:0]    wbm_stb_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [31:0]     wbm_dat_o;
  logic [N-1:0]    wbm_ack_o;
  logic [N-1:0]    wbm_err_o;
  logic [N-1:0]    wbm_rty_o;
  logic [31:0]     wbs_adr_o;
  logic [31:0]     wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic            wbs_we_o;
  logic            wbs_cyc_o;
  logic            wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [31:0]     wbs_dat_i;
  logic            wbs_ack_i;
  logic            wbs_err_i;
  logic            wbs_rty_i;
  logic [N-1:0]    grant_o;

  assign wbm_adr_i = {m_adr[1], m_adr[0]};
  assign wbm_dat_i = {m_dat[1], m_dat[0]};
  assign wbm_sel_i = 8'hFF;
  assign wbm_we_i  = {m_we[1], m_we[0]};
  assign wbm_cyc_i = {m_cyc[1], m_cyc[0]};
  assign wbm_stb_i = {m_stb[1], m_stb[0]};
  assign wbm_cti_i = {m_cti[1], m_cti[0]};
  assign wbm_bte_i = '0;

  wb_rr_arbiter #(
    .NUM_MASTERS(N),
    .AW(32),
    .DW(32),
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i),
    .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i),
    .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i),
    .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o)
  );

  // Slave model: acks sl_lat+1 cycles after it first sees stb.
  logic sack;
  int   wcnt;
  logic sl_en;
  int   sl_lat;
  logic f_ack;
  logic f_err;
  logic f_rty;

  assign wbs_ack_i = sack | f_ack;
  assign wbs_err_i = f_err;
  assign wbs_rty_i = f_rty;
  assign wbs_dat_i = sack ? (wbs_adr_o ^ KEY) : '0;

  always @(posedge clk) begin
    if (rst) begin
      sack <= 1'b0;
      wcnt <= 0;
    end else begin
      sack <= 1'b0;
      if (sl_en && wbs_cyc_o && wbs_stb_o && !sack) begin
        if (wcnt == sl_lat) begin
          sack <= 1'b1;
          wcnt <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  exp_t q0[$];
  exp_t q1[$];

  exp_t         me;
  logic [N-1:0] me_oh;

  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < N; m++) begin
        if (wbm_ack_o[m]) begin
          n_chk++;
          if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            $display("FAIL ack_m%0d: got unexpected ack=%b, want none", m, wbm_ack_o);
          end else begin
            if (m == 0) me = q0.pop_front();
            else        me = q1.pop_front();
            me_oh    = '0;
            me_oh[m] = 1'b1;
            if (wbs_adr_o !== me.adr || wbm_dat_o !== me.dat ||
                wbs_cti_o !== me.cti || wbm_ack_o !== me_oh) begin
              $display("FAIL ack_m%0d: got adr=%h dat=%h cti=%b ack=%b, want adr=%h dat=%h cti=%b ack=%b",
                       m, wbs_adr_o, wbm_dat_o, wbs_cti_o, wbm_ack_o,
                       me.adr, me.dat, me.cti, me_oh);
            end else begin
              n_pass++;
            end
          end
        end
      end
    end
  end

  // Grant history: every new non-zero owner.
  logic       rec_en;
  logic [1:0] rec[$];
  logic [1:0] prev_g;

  always @(negedge clk) begin
    if (rec_en && grant_o != 0 && grant_o != prev_g) rec.push_back(grant_o);
    prev_g <= grant_o;
  end

  task automatic master_xfer(input int m, input logic [31:0] base, input int beats);
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_we[m]  = 1'b1;
    for (int b = 0; b < beats; b++) begin
      logic [2:0] c;
      c = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      m_adr[m] = base + 32'(4 * b);
      m_dat[m] = ~m_adr[m];
      m_cti[m] = c;
      e.adr = m_adr[m];
      e.dat = m_adr[m] ^ KEY;
      e.cti = c;
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!wbm_ack_o[m] && t < 100);
      if (!wbm_ack_o[m]) begin
        n_chk++;
        $display("FAIL xfer_timeout_m%0d: got no ack after %0d cycles, want ack", m, t);
      end
      @(posedge clk);
      #1;
    end
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant_o);
    else n_pass++;
    n_chk++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cti_o, wbs_adr_o} !== '0)
      $display("FAIL rst_wbs: got cyc=%b stb=%b we=%b cti=%b adr=%h want all 0",
               wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cti_o, wbs_adr_o);
    else n_pass++;
    n_chk++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== '0)
      $display("FAIL rst_wbm: got ack=%b err=%b rty=%b want 0", wbm_ack_o, wbm_err_o, wbm_rty_o);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    m_we[1]  = 1'b1;
    m_adr[1] = 32'h0000_0100;
    m_dat[1] = 32'hDEAD_BEEF;
    m_cti[1] = 3'b000;
    e.adr = 32'h100;
    e.dat = 32'h100 ^ KEY;
    e.cti = 3'b000;
    q1.push_back(e);
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b00) $display("FAIL single_lat: got grant=%b want 00", grant_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b10 || wbs_cyc_o !== 1'b1 || wbs_stb_o !== 1'b1)
      $display("FAIL single_grant: got grant=%b cyc=%b stb=%b want 10 1 1",
               grant_o, wbs_cyc_o, wbs_stb_o);
    else n_pass++;
    n_chk++;
    if (wbs_adr_o !== 32'h100 || wbs_dat_o !== 32'hDEAD_BEEF || wbs_we_o !== 1'b1)
      $display("FAIL single_mux: got adr=%h dat=%h we=%b want 00000100 deadbeef 1",
               wbs_adr_o, wbs_dat_o, wbs_we_o);
    else n_pass++;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wbm_ack_o[1] && t < 20);
    n_chk++;
    if (t !== 2) $display("FAIL single_ack_cycle: got ack %0d cycles after grant, want 2", t);
    else n_pass++;
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b00) $display("FAIL single_release: got grant=%b want 00", grant_o);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] got;
    logic [1:0] want;
    rec.delete();
    rec_en = 1'b1;
    fork
      begin
        master_xfer(0, 32'h1000, 1);
        master_xfer(0, 32'h1010, 1);
      end
      begin
        master_xfer(1, 32'h2000, 1);
        master_xfer(1, 32'h2010, 1);
      end
    join
    repeat (2) @(posedge clk);
    rec_en = 1'b0;
    n_chk++;
    if (rec.size() != 4) $display("FAIL rr_count: got %0d grants want 4", rec.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      got  = (i < rec.size()) ? rec[i] : 2'bxx;
      n_chk++;
      if (got !== want) $display("FAIL rr_order_%0d: got %b want %b", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    logic [1:0] got;
    rec.delete();
    rec_en = 1'b1;
    fork
      master_xfer(0, 32'h3000, 4);
      begin
        @(posedge clk);
        master_xfer(1, 32'h4000, 1);
      end
    join
    repeat (2) @(posedge clk);
    rec_en = 1'b0;
    n_chk++;
    if (rec.size() != 2) $display("FAIL burst_count: got %0d grants want 2", rec.size());
    else n_pass++;
    got = (rec.size() > 0) ? rec[0] : 2'bxx;
    n_chk++;
    if (got !== 2'b01) $display("FAIL burst_first: got %b want 01", got);
    else n_pass++;
    got = (rec.size() > 1) ? rec[1] : 2'bxx;
    n_chk++;
    if (got !== 2'b10) $display("FAIL burst_second: got %b want 10", got);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int errs[$];
    int v;
    sl_en = 1'b0;
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h5000;
    m_cti[0] = 3'b000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wbm_err_o[0]) begin
        errs.push_back(c);
        n_chk++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 ||
            wbm_ack_o !== 2'b00 || wbm_err_o !== 2'b01)
          $display("FAIL wd_abort_cycle_%0d: got cyc=%b stb=%b ack=%b err=%b want 0 0 00 01",
                   c, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o);
        else n_pass++;
      end
      if (c == 10) begin
        n_chk++;
        if (wbs_cyc_o !== 1'b1) $display("FAIL wd_resume: got cyc=%b want 1", wbs_cyc_o);
        else n_pass++;
      end
      @(posedge clk);
      #1;
      f_ack = (c == 8);
    end
    f_ack    = 1'b0;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    n_chk++;
    if (errs.size() != 2) $display("FAIL wd_count: got %0d errs want 2", errs.size());
    else n_pass++;
    v = (errs.size() > 0) ? errs[0] : -1;
    n_chk++;
    if (v != TO + 1) $display("FAIL wd_first: got cycle %0d want %0d", v, TO + 1);
    else n_pass++;
    v = (errs.size() > 1) ? errs[1] : -1;
    n_chk++;
    if (v != 2 * (TO + 1)) $display("FAIL wd_second: got cycle %0d want %0d", v, 2 * (TO + 1));
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    sl_en = 1'b1;
  endtask

  task automatic test_err_rty();
    sl_en = 1'b0;
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    m_adr[1] = 32'h6100;
    repeat (2) @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b10) $display("FAIL er_grant: got %b want 10", grant_o);
    else n_pass++;
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h6000;
    f_err    = 1'b1;
    @(negedge clk);
    n_chk++;
    if (wbm_err_o !== 2'b10 || wbm_rty_o !== 2'b00 || wbm_ack_o !== 2'b00)
      $display("FAIL er_err: got err=%b rty=%b ack=%b want 10 00 00", wbm_err_o, wbm_rty_o, wbm_ack_o);
    else n_pass++;
    @(posedge clk);
    #1;
    f_err = 1'b0;
    f_rty = 1'b1;
    @(negedge clk);
    n_chk++;
    if (wbm_rty_o !== 2'b10 || wbm_err_o !== 2'b00 || wbm_ack_o !== 2'b00)
      $display("FAIL er_rty: got rty=%b err=%b ack=%b want 10 00 00", wbm_rty_o, wbm_err_o, wbm_ack_o);
    else n_pass++;
    @(posedge clk);
    #1;
    f_rty    = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b01 || wbs_adr_o !== 32'h6000)
      $display("FAIL er_handover: got grant=%b adr=%h want 01 00006000", grant_o, wbs_adr_o);
    else n_pass++;
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sl_en = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    int   t;
    sl_lat = 0;
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h7000;
    m_cti[0] = 3'b010;
    e.adr = 32'h7000;
    e.dat = 32'h7000 ^ KEY;
    e.cti = 3'b010;
    q0.push_back(e);
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    m_adr[1] = 32'h8000;
    m_cti[1] = 3'b000;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wbm_ack_o[0] && t < 20);
    if (!wbm_ack_o[0]) begin
      n_chk++;
      $display("FAIL rmb_beat1: got no ack after %0d cycles, want ack", t);
    end
    @(posedge clk);
    #1;
    m_adr[0] = 32'h7004;
    rst      = 1'b1;
    sl_en    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b00 || wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0)
      $display("FAIL rmb_reset: got grant=%b cyc=%b stb=%b want 00 0 0", grant_o, wbs_cyc_o, wbs_stb_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b01 || wbs_adr_o !== 32'h7004)
      $display("FAIL rmb_rearb: got grant=%b adr=%h want 01 00007004", grant_o, wbs_adr_o);
    else n_pass++;
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sl_en  = 1'b1;
    sl_lat = 1;
  endtask

  initial begin
    rst    = 1'b1;
    sl_en  = 1'b1;
    sl_lat = 1;
    f_ack  = 1'b0;
    f_err  = 1'b0;
    f_rty  = 1'b0;
    rec_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_adr[i] = '0;
      m_dat[i] = '0;
      m_cti[i] = '0;
      m_cyc[i] = 1'b0;
      m_stb[i] = 1'b0;
      m_we[i]  = 1'b0;
    end
    test_reset();
    test_single();
    repeat (2) @(posedge clk);
    do_reset();
    test_contention();
    test_burst();
    test_watchdog();
    test_err_rty();
    test_reset_mid_burst();
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL pending_acks: got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
